// File: rtl/ex_mem_if.sv
// EX/MEM pipeline boundary signals: EX-side inputs, MEM-side registered outputs,
// and the multi-cycle partial-product loop back to EX.
interface ex_mem_if;
    logic        flush;
    logic        ex_stall;
    logic        mem_stall;

    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;

    // The pipeline register itself.
    modport slave (
        input  flush, ex_stall, mem_stall,
        input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        input  ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        output mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
    );

    // The surrounding EX stage / stall controller.
    modport master (
        output flush, ex_stall, mem_stall,
        output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        output ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        input  mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush, hold, bubble and capture, plus the
// MADD/MSUB partial-product loop that survives EX stalls.
module ex_mem (
    input  logic     clk,
    input  logic     rst,
    ex_mem_if.slave  bus
);

    logic [4:0]  wd_q,       wd_d;
    logic        wreg_q,     wreg_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;
    logic        whilo_q,    whilo_d;
    logic [7:0]  aluop_q,    aluop_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] reg2_q,     reg2_d;
    logic [63:0] hilo_tmp_q, hilo_tmp_d;
    logic [1:0]  cnt_q,      cnt_d;

    always_comb begin
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        whilo_d    = whilo_q;
        aluop_d    = aluop_q;
        mem_addr_d = mem_addr_q;
        reg2_d     = reg2_q;
        hilo_tmp_d = hilo_tmp_q;
        cnt_d      = cnt_q;

        if (bus.flush) begin
            wd_d       = '0;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            hi_d       = '0;
            lo_d       = '0;
            whilo_d    = 1'b0;
            aluop_d    = '0;
            mem_addr_d = '0;
            reg2_d     = '0;
            hilo_tmp_d = '0;
            cnt_d      = '0;
        end else if (bus.mem_stall) begin
            // Hold: defaults already retain every register.
        end else if (bus.ex_stall) begin
            // Bubble keeps the multi-cycle partial result alive for EX.
            wd_d       = '0;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            hi_d       = '0;
            lo_d       = '0;
            whilo_d    = 1'b0;
            aluop_d    = '0;
            mem_addr_d = '0;
            reg2_d     = '0;
            hilo_tmp_d = bus.hilo_temp_i;
            cnt_d      = bus.cnt_i;
        end else begin
            wd_d       = bus.ex_wd;
            wreg_d     = bus.ex_wreg;
            wdata_d    = bus.ex_wdata;
            hi_d       = bus.ex_hi;
            lo_d       = bus.ex_lo;
            whilo_d    = bus.ex_whilo;
            aluop_d    = bus.ex_aluop;
            mem_addr_d = bus.ex_mem_addr;
            reg2_d     = bus.ex_reg2;
            hilo_tmp_d = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            whilo_q    <= 1'b0;
            aluop_q    <= '0;
            mem_addr_q <= '0;
            reg2_q     <= '0;
            hilo_tmp_q <= '0;
            cnt_q      <= '0;
        end else begin
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            whilo_q    <= whilo_d;
            aluop_q    <= aluop_d;
            mem_addr_q <= mem_addr_d;
            reg2_q     <= reg2_d;
            hilo_tmp_q <= hilo_tmp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.mem_wd       = wd_q;
    assign bus.mem_wreg     = wreg_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_hi       = hi_q;
    assign bus.mem_lo       = lo_q;
    assign bus.mem_whilo    = whilo_q;
    assign bus.mem_aluop    = aluop_q;
    assign bus.mem_mem_addr = mem_addr_q;
    assign bus.mem_reg2     = reg2_q;
    assign bus.hilo_temp_o  = hilo_tmp_q;
    assign bus.cnt_o        = cnt_q;

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
Parameters: none.
REQ-001 The block SHALL expose the following ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  exception flush; discards the in-flight instruction.
- ex_stall  in  1  EX stage stalled this cycle.
- mem_stall  in  1  MEM stage stalled this cycle.
- ex_wd  in  5  destination GPR address from EX.
- ex_wreg  in  1  GPR write enable from EX.
- ex_wdata  in  32  GPR write data from EX.
- ex_hi  in  32  HI write value from EX.
- ex_lo  in  32  LO write value from EX.
- ex_whilo  in  1  HI/LO write enable from EX.
- ex_aluop  in  8  ALU opcode, for load/store decode in MEM.
- ex_mem_addr  in  32  load/store effective address.
- ex_reg2  in  32  store data.
- hilo_temp_i  in  64  multi-cycle MADD/MSUB partial product from EX.
- cnt_i  in  2  multi-cycle step count from EX.
- mem_wd  out  5  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  32  registered ex_wdata.
- mem_hi  out  32  registered ex_hi.
- mem_lo  out  32  registered ex_lo.
- mem_whilo  out  1  registered ex_whilo.
- mem_aluop  out  8  registered ex_aluop.
- mem_mem_addr  out  32  registered ex_mem_addr.
- mem_reg2  out  32  registered ex_reg2.
- hilo_temp_o  out  64  partial product returned to EX.
- cnt_o  out  2  step count returned to EX.

Function
REQ-002 All outputs SHALL be registered and update only on the rising edge of clk; there is no combinational input-to-output path.
REQ-003 Register update priority SHALL be: rst > flush > hold > bubble > capture, as defined in REQ-004 to REQ-008.
REQ-004 Capture (ex_stall=0, mem_stall=0): every mem_* output SHALL take its ex_* input; hilo_temp_o SHALL load 0 and cnt_o SHALL load 0.
REQ-005 Bubble (ex_stall=1, mem_stall=0): every mem_* output SHALL load 0, so mem_wreg=0 and mem_whilo=0.
REQ-006 In a bubble, hilo_temp_o SHALL load hilo_temp_i and cnt_o SHALL load cnt_i, preserving the partial result across a stalled multi-cycle op.
REQ-007 Hold (mem_stall=1): all outputs, including hilo_temp_o and cnt_o, SHALL retain their values, regardless of ex_stall.
REQ-008 Flush (flush=1): all outputs SHALL load 0 in that cycle, overriding both stall inputs.
REQ-009 Pipeline latency SHALL be exactly one cycle from EX inputs to mem_* outputs when no stall or flush is active.
REQ-010 The combination ex_stall=0, mem_stall=1 is not produced by the stall controller; if it occurs, the block SHALL hold per REQ-007 and SHALL NOT drop or duplicate state.
REQ-011 The data fields (wd, wdata, hi, lo, aluop, mem_addr, reg2) SHALL pass through unmodified when captured; no sign or width conversion is applied.
REQ-012 A bubble SHALL never assert mem_wreg or mem_whilo, so no architectural write occurs downstream.

Reset
REQ-013 When rst=1 at a clock edge, every output SHALL be 0 on the following cycle, overriding flush and both stall inputs.
REQ-014 When rst=1 at a clock edge, hilo_temp_o SHALL be 64'h0 and cnt_o SHALL be 2'b00.
REQ-015 The first capture after rst deasserts SHALL occur on the first edge with rst=0, ex_stall=0, mem_stall=0 and flush=0.

Verification
REQ-016 The bench SHALL cover the following directed scenarios:
- Capture: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF, no stall -> next cycle mem_wd=3, mem_wreg=1, mem_wdata=32'hDEADBEEF, cnt_o=0.
- Bubble: ex_stall=1, mem_stall=0, hilo_temp_i=64'h1234_5678_9ABC_DEF0, cnt_i=1 -> mem_wreg=0, mem_whilo=0, mem_wdata=0, hilo_temp_o=64'h1234_5678_9ABC_DEF0, cnt_o=1.
- Hold: load mem_wdata=32'hA5A5A5A5, then ex_stall=1 and mem_stall=1 for 3 cycles while inputs change -> mem_wdata stays 32'hA5A5A5A5 and hilo_temp_o/cnt_o are unchanged.
- Flush priority: flush=1, ex_stall=1, mem_stall=1, outputs previously non-zero -> all outputs 0 on the next cycle.
- Reset mid-operation: cnt_o=1 during a bubble, then rst=1 for one edge -> all outputs 0; after rst=0 with no stall, the next edge captures the inputs.
- HI/LO path: ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 -> mem_whilo=1, mem_hi=1, mem_lo=2 one cycle later.
